store_monitor: RTL and testbench
================================

Name: store_monitor

Overview:
- Parametrised, synthesizable successor to the single-cycle core's bench-level store probe; sits beside the core top and snoops the data-memory store bus (write_enable / data_address / write_data).
- Checks stores in order against a loadable expected-store table, detects the end-of-test store to DONE_ADDR, and enforces a cycle timeout.
- Logs every store into a readable FIFO and reports pass/fail with a cause code and counters.

Parameters:
- DATA_W, 32, store data width
- ADDR_W, 32, store address width
- NUM_CHECKS, 8, expected-store table entries (power of 2)
- LOG_DEPTH, 16, store-log FIFO depth (power of 2)
- DONE_ADDR, 32'h0000_00FC, end-of-test store address
- TIMEOUT_CYCLES, 1000, RUN-state cycle budget
- CNT_W, 16, width of store_count and cycle_count

Ports:
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0 at a rising clk edge)
- start  in  1  arm the monitor (IDLE/PASS/FAIL -> RUN)
- mon_write_enable  in  1  core store strobe
- mon_data_address  in  ADDR_W  core store address
- mon_write_data  in  DATA_W  core store data
- exp_load  in  1  write table entry (honoured in IDLE only)
- exp_index  in  $clog2(NUM_CHECKS)  table entry index
- exp_addr  in  ADDR_W  expected address
- exp_data  in  DATA_W  expected data
- log_valid  out  1  log FIFO not empty
- log_ready  in  1  pop log head
- log_addr  out  ADDR_W  head entry address
- log_data  out  DATA_W  head entry data
- log_overflow  out  1  sticky: a store was dropped because the FIFO was full
- busy  out  1  state == RUN
- done  out  1  state is PASS or FAIL
- pass  out  1  state == PASS
- fail_code  out  3  0 none, 1 bad done value, 2 data mismatch, 3 timeout, 4 missing expected stores
- store_count  out  CNT_W  stores seen in current run (saturating)
- cycle_count  out  CNT_W  RUN cycles elapsed (saturating)

Behaviour:
- Reset: state IDLE; all outputs 0; FIFO empty; all table valid bits 0; match pointer 0; log_overflow 0. Reset mid-run aborts to IDLE and clears the table.
- FSM states: IDLE, RUN, PASS, FAIL.
- IDLE: exp_load sets entry exp_index and its valid bit. nvalid = number of valid entries, which must be loaded from index 0 contiguously. exp_load is ignored in any state other than IDLE.
- start in IDLE, PASS or FAIL: next state RUN; store_count, cycle_count, match pointer and fail_code cleared. The table and the FIFO contents are kept. start during RUN is ignored.
- RUN, each cycle: cycle_count increments.
- RUN, when mon_write_enable=1:
  - store_count increments.
  - {addr, data} is pushed to the FIFO. If the FIFO is full and no pop occurs that cycle, the entry is dropped and log_overflow is set.
  - Done store (addr == DONE_ADDR): not checked against the table. If data != 1, go to FAIL with code 1. Else if ptr < nvalid, go to FAIL with code 4. Else go to PASS.
  - Other stores with ptr < nvalid and addr == exp_addr[ptr]: if data matches, ptr increments; otherwise go to FAIL with code 2.
  - Stores to addresses not equal to exp_addr[ptr] are logged only.
- Timeout: a RUN cycle with cycle_count == TIMEOUT_CYCLES-1 and no terminating store goes to FAIL with code 3. A terminating store in that same cycle takes priority over the timeout.
- Latency: a store sampled at edge N shows on log_valid/pass/done/fail_code after edge N. There are no combinational paths from the mon_* inputs to outputs.
- FIFO:
  - Pop occurs when log_valid && log_ready, in any state.
  - Simultaneous push and pop when full: both succeed, no overflow.
  - Pop when empty has no effect.
  - Pointers wrap modulo LOG_DEPTH.
  - log_addr/log_data are the registered head entry and are 0 when empty.
- PASS/FAIL: done=1 and busy=0 are held until start or reset. Stores in these states are ignored: not logged, not counted.
- Counters saturate at all-ones.

Test Plan:
- Load entries 0:(0x10, 0xAA) and 1:(0x14, 0xBB), start, then stores (0x10, 0xAA), (0x14, 0xBB), (0xFC, 1) -> pass=1, done=1, fail_code=0, store_count=3, and the FIFO pops those 3 entries in order.
- Same table, stores (0x10, 0xAA), (0x14, 0xBC) -> FAIL with fail_code=2 the cycle after the second store; a subsequent (0xFC, 1) store is ignored and store_count stays 2.
- Same table, stores (0x10, 0xAA), (0xFC, 1) -> fail_code=4. Empty table with store (0xFC, 0) -> fail_code=1.
- TIMEOUT_CYCLES=20, start with no stores -> done=1 and fail_code=3 after exactly 20 RUN cycles, cycle_count=19. Repeat with (0xFC, 1) in cycle 19 -> pass=1.
- LOG_DEPTH=4, log_ready=0, six stores -> 4 entries retained, log_overflow=1; then full FIFO with log_ready=1 plus a store in the same cycle -> no additional drop.
- Drive reset=0 mid-RUN -> next edge: busy=0, done=0, FIFO empty, table cleared; start then (0xFC, 1) -> pass=1.

Source files
------------

// File: rtl/store_monitor.sv
// Snoops the core's data-memory store bus: checks stores in order against a loadable
// expected-store table, logs every RUN-state store into a FIFO and reports pass/fail.
module store_monitor #(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 32,
    parameter int                NUM_CHECKS     = 8,
    parameter int                LOG_DEPTH      = 16,
    parameter logic [ADDR_W-1:0] DONE_ADDR      = 32'h0000_00FC,
    parameter int                TIMEOUT_CYCLES = 1000,
    parameter int                CNT_W          = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          mon_write_enable,
    input  logic [ADDR_W-1:0]             mon_data_address,
    input  logic [DATA_W-1:0]             mon_write_data,
    input  logic                          exp_load,
    input  logic [$clog2(NUM_CHECKS)-1:0] exp_index,
    input  logic [ADDR_W-1:0]             exp_addr,
    input  logic [DATA_W-1:0]             exp_data,
    output logic                          log_valid,
    input  logic                          log_ready,
    output logic [ADDR_W-1:0]             log_addr,
    output logic [DATA_W-1:0]             log_data,
    output logic                          log_overflow,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [2:0]                    fail_code,
    output logic [CNT_W-1:0]              store_count,
    output logic [CNT_W-1:0]              cycle_count
);

    localparam int IDX_W = $clog2(NUM_CHECKS);
    localparam int PTR_W = IDX_W + 1;
    localparam int LPW   = $clog2(LOG_DEPTH);
    localparam int LCW   = LPW + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LCW-1:0]   LOG_FULL     = LCW'(LOG_DEPTH);

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_BAD_DONE = 3'd1;
    localparam logic [2:0] FC_MISMATCH = 3'd2;
    localparam logic [2:0] FC_TIMEOUT  = 3'd3;
    localparam logic [2:0] FC_MISSING  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         fail_code_q, fail_code_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   store_count_q, store_count_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic [ADDR_W-1:0]  tbl_addr_q [NUM_CHECKS];
    logic [ADDR_W-1:0]  tbl_addr_d [NUM_CHECKS];
    logic [DATA_W-1:0]  tbl_data_q [NUM_CHECKS];
    logic [DATA_W-1:0]  tbl_data_d [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] tbl_valid_q, tbl_valid_d;
    logic [PTR_W-1:0]   nvalid;
    logic               prefix;

    logic [ADDR_W-1:0]  mem_addr_q [LOG_DEPTH];
    logic [ADDR_W-1:0]  mem_addr_d [LOG_DEPTH];
    logic [DATA_W-1:0]  mem_data_q [LOG_DEPTH];
    logic [DATA_W-1:0]  mem_data_d [LOG_DEPTH];
    logic [LPW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LPW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LCW-1:0]     log_cnt_q, log_cnt_d;
    logic               overflow_q, overflow_d;
    logic               push_req, push, pop, log_full;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Only the contiguous run of valid entries starting at index 0 is checked.
    always_comb begin
        nvalid = '0;
        prefix = 1'b1;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            prefix = prefix & tbl_valid_q[i];
            if (prefix) nvalid = nvalid + PTR_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        fail_code_d   = fail_code_q;
        ptr_d         = ptr_q;
        store_count_d = store_count_q;
        cycle_count_d = cycle_count_q;
        tbl_addr_d    = tbl_addr_q;
        tbl_data_d    = tbl_data_q;
        tbl_valid_d   = tbl_valid_q;
        case (state_q)
            S_RUN: begin
                if (mon_write_enable) begin
                    store_count_d = sat_inc(store_count_q);
                    if (mon_data_address == DONE_ADDR) begin
                        if (mon_write_data != DATA_W'(1)) begin
                            state_d     = S_FAIL;
                            fail_code_d = FC_BAD_DONE;
                        end else if (ptr_q < nvalid) begin
                            state_d     = S_FAIL;
                            fail_code_d = FC_MISSING;
                        end else begin
                            state_d = S_PASS;
                        end
                    end else if ((ptr_q < nvalid) &&
                                 (mon_data_address == tbl_addr_q[ptr_q[IDX_W-1:0]])) begin
                        if (mon_write_data == tbl_data_q[ptr_q[IDX_W-1:0]]) begin
                            ptr_d = ptr_q + PTR_W'(1);
                        end else begin
                            state_d     = S_FAIL;
                            fail_code_d = FC_MISMATCH;
                        end
                    end
                end
                // A terminating store wins over the timeout; the last budget cycle is not counted.
                if (state_d == S_RUN) begin
                    if (cycle_count_q == TIMEOUT_LAST) begin
                        state_d     = S_FAIL;
                        fail_code_d = FC_TIMEOUT;
                    end else begin
                        cycle_count_d = sat_inc(cycle_count_q);
                    end
                end
            end
            default: begin
                if ((state_q == S_IDLE) && exp_load) begin
                    tbl_addr_d[exp_index]  = exp_addr;
                    tbl_data_d[exp_index]  = exp_data;
                    tbl_valid_d[exp_index] = 1'b1;
                end
                if (start) begin
                    state_d       = S_RUN;
                    fail_code_d   = FC_NONE;
                    ptr_d         = '0;
                    store_count_d = '0;
                    cycle_count_d = '0;
                end
            end
        endcase
    end

    assign push_req = (state_q == S_RUN) && mon_write_enable;
    assign log_full = (log_cnt_q == LOG_FULL);
    assign pop      = log_valid && log_ready;
    assign push     = push_req && (!log_full || pop);

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        log_cnt_d  = log_cnt_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_addr_d[wr_ptr_q] = mon_data_address;
            mem_data_d[wr_ptr_q] = mon_write_data;
            wr_ptr_d             = wr_ptr_q + LPW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + LPW'(1);
        if (push && !pop) begin
            log_cnt_d = log_cnt_q + LCW'(1);
        end else if (pop && !push) begin
            log_cnt_d = log_cnt_q - LCW'(1);
        end
        if (push_req && log_full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            fail_code_q   <= FC_NONE;
            ptr_q         <= '0;
            store_count_q <= '0;
            cycle_count_q <= '0;
            tbl_addr_q    <= '{default: '0};
            tbl_data_q    <= '{default: '0};
            tbl_valid_q   <= '0;
            mem_addr_q    <= '{default: '0};
            mem_data_q    <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            log_cnt_q     <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fail_code_q   <= fail_code_d;
            ptr_q         <= ptr_d;
            store_count_q <= store_count_d;
            cycle_count_q <= cycle_count_d;
            tbl_addr_q    <= tbl_addr_d;
            tbl_data_q    <= tbl_data_d;
            tbl_valid_q   <= tbl_valid_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            log_cnt_q     <= log_cnt_d;
            overflow_q    <= overflow_d;
        end
    end

    assign log_valid    = (log_cnt_q != '0);
    assign log_addr     = log_valid ? mem_addr_q[rd_ptr_q] : '0;
    assign log_data     = log_valid ? mem_data_q[rd_ptr_q] : '0;
    assign log_overflow = overflow_q;
    assign busy         = (state_q == S_RUN);
    assign done         = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass         = (state_q == S_PASS);
    assign fail_code    = fail_code_q;
    assign store_count  = store_count_q;
    assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_store_monitor.sv
// Randomised bench for store_monitor: a queue-based model predicts log entries and run
// results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_store_monitor;

    localparam int          DATA_W     = 32;
    localparam int          ADDR_W     = 32;
    localparam int          NUM_CHECKS = 8;
    localparam int          LOG_DEPTH  = 4;
    localparam int          TIMEOUT    = 20;
    localparam int          CNT_W      = 16;
    localparam logic [31:0] DONE_ADDR  = 32'h0000_00FC;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              mon_write_enable = 1'b0;
    logic [ADDR_W-1:0] mon_data_address = '0;
    logic [DATA_W-1:0] mon_write_data = '0;
    logic              exp_load = 1'b0;
    logic [2:0]        exp_index = '0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_data = '0;
    logic              log_valid;
    logic              log_ready = 1'b0;
    logic [ADDR_W-1:0] log_addr;
    logic [DATA_W-1:0] log_data;
    logic              log_overflow;
    logic              busy, done, pass;
    logic [2:0]        fail_code;
    logic [CNT_W-1:0]  store_count, cycle_count;

    store_monitor #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CHECKS(NUM_CHECKS), .LOG_DEPTH(LOG_DEPTH),
        .DONE_ADDR(DONE_ADDR), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .mon_write_enable(mon_write_enable), .mon_data_address(mon_data_address),
        .mon_write_data(mon_write_data), .exp_load(exp_load), .exp_index(exp_index),
        .exp_addr(exp_addr), .exp_data(exp_data), .log_valid(log_valid),
        .log_ready(log_ready), .log_addr(log_addr), .log_data(log_data),
        .log_overflow(log_overflow), .busy(busy), .done(done), .pass(pass),
        .fail_code(fail_code), .store_count(store_count), .cycle_count(cycle_count)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_log_q[$];
    logic [63:0] exp_res_q[$];

    // Reference model: 0 idle, 1 running, 2 ended.
    int          m_state = 0;
    logic [31:0] m_addr [NUM_CHECKS];
    logic [31:0] m_data [NUM_CHECKS];
    bit          m_valid [NUM_CHECKS];
    int          m_ptr, m_count, m_cyc;
    bit          m_ovf = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_nvalid();
        int n = 0;
        while (n < NUM_CHECKS && m_valid[n]) n++;
        return n;
    endfunction

    // One clock: update the model from the inputs about to be sampled, then advance.
    task automatic step();
        bit term;
        int code;
        if (!reset) begin
            m_state = 0;
            m_ovf   = 0;
            exp_log_q.delete();
            for (int i = 0; i < NUM_CHECKS; i++) m_valid[i] = 0;
        end else begin
            if (m_state == 0 && exp_load) begin
                m_addr[exp_index]  = exp_addr;
                m_data[exp_index]  = exp_data;
                m_valid[exp_index] = 1;
            end
            if (m_state == 1) begin
                term = 0;
                code = 0;
                if (mon_write_enable) begin
                    m_count++;
                    if (exp_log_q.size() < LOG_DEPTH || (log_ready && exp_log_q.size() > 0))
                        exp_log_q.push_back({mon_data_address, mon_write_data});
                    else
                        m_ovf = 1;
                    if (mon_data_address == DONE_ADDR) begin
                        term = 1;
                        if (mon_write_data != 1)   code = 1;
                        else if (m_ptr < m_nvalid()) code = 4;
                    end else if (m_ptr < m_nvalid() && mon_data_address == m_addr[m_ptr]) begin
                        if (mon_write_data == m_data[m_ptr]) m_ptr++;
                        else begin term = 1; code = 2; end
                    end
                end
                if (!term && m_cyc == TIMEOUT - 1) begin term = 1; code = 3; end
                if (term) begin
                    exp_res_q.push_back({10'b0, 1'b1, 1'b0, (code == 0), 3'(code),
                                         16'(m_count), 32'(cyc + 1)});
                    m_state = 2;
                end
                m_cyc++;
            end else if (start) begin
                m_state = 1;
                m_ptr   = 0;
                m_count = 0;
                m_cyc   = 0;
            end
        end
        @(posedge clk);
        #1;
        start            = 1'b0;
        mon_write_enable = 1'b0;
        exp_load         = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mon_write_enable = 1'b1;
        mon_data_address = a;
        mon_write_data   = d;
        step();
    endtask

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
        exp_load  = 1'b1;
        exp_index = 3'(i);
        exp_addr  = a;
        exp_data  = d;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
    endtask

    task automatic do_reset();
        log_ready = 1'b0;
        reset     = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic drain();
        log_ready = 1'b1;
        idle(LOG_DEPTH + 2);
        check("drained_valid", log_valid, 0);
        check("drained_head", {log_addr, log_data}, 0);
    endtask

    // ---------------- monitor ----------------
    logic done_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (log_valid && log_ready) begin
                if (exp_log_q.size() == 0) check("log_unexpected", {log_addr, log_data}, 0);
                else check("log_entry", {log_addr, log_data}, exp_log_q.pop_front());
            end
            if (done && !done_prev) begin
                if (exp_res_q.size() == 0) check("result_unexpected", {63'b0, done}, 0);
                else check("result", {10'b0, done, busy, pass, fail_code, store_count, 32'(cyc)},
                           exp_res_q.pop_front());
            end
            done_prev = done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int r, nv;
        logic [31:0] a, d;

        idle(2);
        reset = 1'b1;
        check("reset_flags", {log_valid, log_overflow, busy, done, pass, fail_code}, 0);
        check("reset_head", {log_addr, log_data}, 0);
        check("reset_counts", {store_count, cycle_count}, 0);

        // In-order pass with the log drained as it fills.
        load(0, 32'h10, 32'hAA);
        load(1, 32'h14, 32'hBB);
        log_ready = 1'b1;
        do_start();
        check("busy_after_start", {busy, done}, 2'b10);
        store(32'h10, 32'hAA);
        store(32'h14, 32'hBB);
        store(DONE_ADDR, 32'h1);
        check("t1_pass", {pass, done, fail_code, store_count}, {1'b1, 1'b1, 3'd0, 16'd3});
        drain();

        // Data mismatch, then a late done store is ignored.
        do_start();
        store(32'h10, 32'hAA);
        store(32'h14, 32'hBC);
        check("t2_mismatch", {done, fail_code}, {1'b1, 3'd2});
        store(DONE_ADDR, 32'h1);
        check("t2_ignored", {pass, fail_code, store_count}, {1'b0, 3'd2, 16'd2});
        drain();

        // Missing expected stores, then bad done value on an empty table.
        do_start();
        store(32'h10, 32'hAA);
        store(DONE_ADDR, 32'h1);
        check("t3_missing", fail_code, 4);
        drain();
        do_reset();
        do_start();
        store(DONE_ADDR, 32'h0);
        check("t3_bad_done", fail_code, 1);
        drain();

        // Timeout exactly at the budget, then a done store in the last cycle wins.
        do_start();
        idle(TIMEOUT);
        check("t4_timeout", {done, fail_code, cycle_count}, {1'b1, 3'd3, 16'(TIMEOUT - 1)});
        do_start();
        idle(TIMEOUT - 1);
        store(DONE_ADDR, 32'h1);
        check("t4_last_cycle_pass", {pass, fail_code}, {1'b1, 3'd0});

        // Overflow with a stalled reader, then push+pop on a full FIFO.
        drain();
        log_ready = 1'b0;
        do_start();
        for (int i = 0; i < 6; i++) store(32'h200 + 32'(i * 4), $urandom);
        check("t5_overflow", log_overflow, m_ovf);
        check("t5_overflow_set", log_overflow, 1);
        log_ready = 1'b1;
        store(32'h300, 32'h5A5A);
        log_ready = 1'b0;
        store(DONE_ADDR, 32'h1);
        check("t5_pass", pass, 1);
        drain();

        // Reset mid-run clears the table and the log.
        do_reset();
        load(0, 32'h10, 32'hAA);
        do_start();
        store(32'h20, 32'h5);
        do_reset();
        check("t6_reset", {busy, done, log_valid, log_overflow}, 0);
        do_start();
        store(DONE_ADDR, 32'h1);
        check("t6_pass_after_reset", {pass, fail_code}, {1'b1, 3'd0});
        drain();

        // Random runs against the model.
        for (int run = 0; run < 25; run++) begin
            do_reset();
            nv = $urandom_range(0, 4);
            for (int i = 0; i < nv; i++) load(i, 32'h10 + 32'($urandom_range(0, 3) * 4), $urandom);
            do_start();
            for (int c = 0; c < 24; c++) begin
                log_ready = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 99);
                if (r < 35 && m_state == 1 && m_ptr < m_nvalid()) begin
                    d = ($urandom_range(0, 7) == 0) ? m_data[m_ptr] ^ 32'h1 : m_data[m_ptr];
                    store(m_addr[m_ptr], d);
                end else if (r < 65) begin
                    a = ($urandom_range(0, 1) != 0) ? 32'h40 + 32'($urandom_range(0, 15))
                                                    : 32'h10 + 32'($urandom_range(0, 3) * 4);
                    store(a, $urandom);
                end else if (r < 72) begin
                    store(DONE_ADDR, ($urandom_range(0, 3) == 0) ? 32'h0 : 32'h1);
                end else begin
                    step();
                end
            end
            check("rnd_overflow", log_overflow, m_ovf);
            check("rnd_done", done, (m_state == 2));
            drain();
        end

        check("res_queue_empty", exp_res_q.size(), 0);
        check("log_queue_empty", exp_log_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
